// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging req_n beat streams into one FIFO write port; one IDLE arbitration cycle per grant, data then passes combinationally.
// fifo_full_n=0 drops s_ready/fifo_wen and holds the grant; FIFO_WR_ARB_PKT_LOCK_EN keeps the grant until s_last so packets never interleave.
module fifo_wr_arbiter #(
    parameter int req_n            = 4,
    parameter int data_width       = 32,
    parameter int simulation_delay = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [req_n-1:0]              s_valid,
    input  logic [req_n*data_width-1:0]   s_data,
    input  logic [req_n-1:0]              s_last,
    output logic [req_n-1:0]              s_ready,
    output logic                          fifo_wen,
    output logic [data_width-1:0]         fifo_din,
    input  logic                          fifo_full_n,
    output logic [$clog2(req_n-1):0]      grant_id,
    output logic                          busy,
    output logic [15:0]                   beat_cnt
);

    localparam int ID_W = $clog2(req_n-1) + 1;

    if (req_n < 2 || req_n > 16 || simulation_delay < 0) begin : g_bad_cfg
        $error("fifo_wr_arbiter: unsupported parameter set");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [15:0]     beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0] win_hi, win_lo, winner;
    logic            hit_hi;
    logic            gnt_vld, gnt_last, end_grant;

    // Lowest valid index at or above rr_ptr, else lowest valid overall (wrap-around).
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        for (int i = req_n-1; i >= 0; i--) begin
            if (s_valid[i]) begin
                win_lo = ID_W'(i);
                if (ID_W'(i) >= rr_ptr_q) begin
                    win_hi = ID_W'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        winner = hit_hi ? win_hi : win_lo;
    end

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_last = 1'b0;
        fifo_din = '0;
        s_ready  = '0;
        for (int i = 0; i < req_n; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                gnt_vld    = s_valid[i];
                gnt_last   = s_last[i];
                fifo_din   = s_data[i*data_width +: data_width];
                s_ready[i] = busy & fifo_full_n;
            end
        end
    end

    assign busy     = (state_q == GRANT);
    assign fifo_wen = gnt_vld & fifo_full_n & busy;
    assign grant_id = grant_id_q;
    assign beat_cnt = beat_cnt_q;

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    assign end_grant = fifo_wen & gnt_last;
`else
    // Beat-level round-robin: s_last carries no meaning here.
    assign end_grant = fifo_wen & (gnt_last | 1'b1);
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|s_valid) begin
                    state_d    = GRANT;
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (fifo_wen && beat_cnt_q != 16'hFFFF) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                end
                if (end_grant) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id_q == ID_W'(req_n-1)) ? '0 : grant_id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester expected-beat queues plus a rule-level round-robin model.
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int IDW = $clog2(N-1) + 1;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      s_valid = '0;
    logic [N*DW-1:0]   s_data = '0;
    logic [N-1:0]      s_last = '0;
    logic [N-1:0]      s_ready;
    logic              fifo_wen;
    logic [DW-1:0]     fifo_din;
    logic              fifo_full_n = 1'b1;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic [15:0]       beat_cnt;

    fifo_wr_arbiter #(.req_n(N), .data_width(DW), .simulation_delay(1)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .fifo_wen(fifo_wen), .fifo_din(fifo_din), .fifo_full_n(fifo_full_n),
        .grant_id(grant_id), .busy(busy), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus state and scoreboard
    beat_t    exp_q[N][$];
    int       wr_log[$];
    beat_t    cur[N];
    bit       pend[N];
    int       pkts_left[N];
    int       beat_left[N];
    logic [N-1:0] acc = '0;
    int       len_min = 1, len_max = 1, vld_pct = 100, full_pct = 0;
    bit       full_force = 1'b0;
    int       n_pushed = 0;

    // Reference model: abstract arbiter state
    bit       m_busy = 1'b0;
    int       m_gid = 0, m_ptr = 0, m_cnt = 0;

    function automatic bit vbit(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (vbit(acc, i)) pend[i] = 1'b0;
            if (!pend[i] && (beat_left[i] > 0 || pkts_left[i] > 0)) begin
                if (beat_left[i] == 0) begin
                    beat_left[i] = int'($urandom_range(len_max, len_min));
                    pkts_left[i]--;
                end
                cur[i].data = $urandom;
                cur[i].last = (beat_left[i] == 1);
                beat_left[i]--;
                pend[i] = 1'b1;
                exp_q[i].push_back(cur[i]);
                n_pushed++;
            end
            s_valid[i] = pend[i] && (int'($urandom_range(99)) < vld_pct);
            s_last[i]  = cur[i].last;
            s_data[i*DW +: DW] = cur[i].data;
        end
        acc = '0;
        fifo_full_n = !full_force && (int'($urandom_range(99)) >= full_pct);
    endtask

    task automatic step();
        @(negedge clk);
        acc = s_valid & s_ready;
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    // Called at posedge+1; asserts reset mid-cycle and checks outputs drop at once.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_now_busy", busy, 0);
        chk("rst_now_ready", s_ready, 0);
        chk("rst_now_wen", fifo_wen, 0);
        chk("rst_now_cnt", beat_cnt, 0);
        chk("rst_now_gid", grant_id, 0);
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pkts_left[i] = 0;
            beat_left[i] = 0;
            cur[i] = '0;
            exp_q[i].delete();
        end
        s_valid = '0; s_last = '0; s_data = '0; acc = '0;
        full_force = 1'b0; full_pct = 0; vld_pct = 100;
        fifo_full_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_log.delete();
        n_pushed = 0;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++)
            if (pend[i] || pkts_left[i] > 0 || beat_left[i] > 0 || exp_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (!all_done() && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain_done", all_done(), 1);
    endtask

    // Monitor: compares DUT outputs with the model, pops expected beats on each transfer
    always @(negedge clk) begin
        beat_t        ent;
        bit           exp_wen, fin;
        logic [N-1:0] exp_rdy;
        int           win, idx;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_ready", s_ready, 0);
            chk("rst_wen", fifo_wen, 0);
            chk("rst_cnt", beat_cnt, 0);
            m_busy = 1'b0; m_ptr = 0; m_gid = 0; m_cnt = 0;
        end else begin
            exp_wen = m_busy && vbit(s_valid, m_gid) && fifo_full_n;
            exp_rdy = (m_busy && fifo_full_n) ? (N'(1) << m_gid) : '0;
            chk("busy", busy, m_busy);
            if (m_busy) chk("grant_id", grant_id, m_gid);
            chk("s_ready", s_ready, exp_rdy);
            chk("fifo_wen", fifo_wen, exp_wen);
            chk("beat_cnt", beat_cnt, m_cnt);
            if (fifo_wen) wr_log.push_back(int'(grant_id));
            fin = 1'b0;
            if (exp_wen) begin
                chk("sb_avail", exp_q[m_gid].size() > 0, 1);
                if (exp_q[m_gid].size() > 0) begin
                    ent = exp_q[m_gid].pop_front();
                    chk("fifo_din", fifo_din, ent.data);
                    fin = LOCK ? ent.last : 1'b1;
                end
                if (m_cnt < 65535) m_cnt++;
                if (fin) begin
                    m_busy = 1'b0;
                    m_ptr = (m_gid + 1) % N;
                end
            end else if (!m_busy && s_valid != '0) begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (win < 0 && vbit(s_valid, idx)) win = idx;
                end
                m_gid = win; m_busy = 1'b1; m_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int e[4];
        bit found;

        // Round-robin over all requesters with 1-beat packets
        apply_reset();
        for (int i = 0; i < N; i++) pkts_left[i] = 3;
        drive_inputs();
        repeat (10) step();
        chk("rr_nwrites", wr_log.size(), 5);
        for (int k = 0; k < 5; k++) chk("rr_order", wr_log[k], k % N);
        drain(500);

        // Req1 3-beat packet, req0 arrives mid-packet
        apply_reset();
        len_min = 3; len_max = 3;
        pkts_left[1] = 1;
        drive_inputs();
        step();
        len_min = 1; len_max = 1;
        pkts_left[0] = 1;
        repeat (3) step();
        chk("pkt_beat_cnt", beat_cnt, LOCK ? 3 : 1);
        repeat (6) step();
        if (LOCK) e = '{1, 1, 1, 0}; else e = '{1, 0, 1, 1};
        chk("pkt_nwrites", wr_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("pkt_order", wr_log[k], e[k]);

        // FIFO full for 5 cycles mid-packet
        apply_reset();
        len_min = 8; len_max = 8;
        pkts_left[1] = 1;
        drive_inputs();
        repeat (3) step();
        full_force = 1'b1;
        repeat (5) begin
            step();
            #3;
            chk("stall_wen", fifo_wen, 0);
            chk("stall_ready", s_ready, 0);
            if (busy) chk("stall_gid", grant_id, 1);
        end
        full_force = 1'b0;
        drain(300);
        chk("stall_nbeats", wr_log.size(), 8);
        for (int k = 0; k < 8; k++) chk("stall_src", wr_log[k], 1);

        // Reset during the 2nd beat of req2
        apply_reset();
        len_min = 4; len_max = 4;
        pkts_left[2] = 1;
        drive_inputs();
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (busy && wr_log.size() == 1) found = 1'b1;
        end
        chk("r2_second_beat", found, 1);
        chk("r2_gid", grant_id, 2);
        apply_reset();
        len_min = 1; len_max = 1;
        pkts_left[0] = 1;
        pkts_left[2] = 1;
        drive_inputs();
        repeat (6) step();
        chk("post_rst_first", wr_log[0], 0);
        chk("post_rst_second", wr_log[1], 2);

        // Req0 and req3 each 2-beat packets
        apply_reset();
        len_min = 2; len_max = 2;
        pkts_left[0] = 1;
        pkts_left[3] = 1;
        drive_inputs();
        repeat (10) step();
        if (LOCK) e = '{0, 0, 3, 3}; else e = '{0, 3, 0, 3};
        chk("two_nwrites", wr_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("two_order", wr_log[k], e[k]);

        // Random traffic with valid gaps and FIFO backpressure
        apply_reset();
        len_min = 1; len_max = 4; vld_pct = 70; full_pct = 25;
        for (int i = 0; i < N; i++) pkts_left[i] = int'($urandom_range(7, 4));
        drive_inputs();
        drain(4000);
        chk("rand_total", wr_log.size(), n_pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
